pwm_duty_decoder: RTL and testbench
===================================

Name: pwm_duty_decoder

Overview:
- Recovers the signed drive command from one motor channel's PWM pin pair (fwd, rev), as produced by motor_cntrl, by measuring high time over fixed windows of 2^PERIOD_W clocks.
- One instance per side (left/right). Used in the motor model, and as a self-checking monitor that closes the loop on motor_cntrl in system benches.
- Reports a signed duty word per window, plus pin-overlap and activity flags.

Parameters:
- PERIOD_W, 10, log2 of PWM period in clocks; window length = 2^PERIOD_W.
- DUTY_W, 11, width of signed duty output; must equal PERIOD_W+1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high (sampled on posedge clk).
- fwd  input  1  forward PWM pin.
- rev  input  1  reverse PWM pin.
- duty  output  DUTY_W  signed recovered command, two's complement, held between updates.
- duty_vld  output  1  one-cycle pulse when duty updates.
- overlap_err  output  1  fwd and rev were both high at least once in the last completed window.
- active  output  1  at least one edge on fwd or rev in the last completed window.

Behaviour:
- Input stage: fwd and rev registered once (fwd_q, rev_q); all counting uses the registered copies. This adds 1 cycle of pin-to-count latency.
- Window counter win_cnt, PERIOD_W bits, free-running from 0. The window ends on the cycle win_cnt == 2^PERIOD_W-1, then wraps to 0.
- Per-window counters fcnt and rcnt, PERIOD_W+1 bits each (range 0..2^PERIOD_W):
  - fwd_q & ~rev_q: fcnt+1.
  - rev_q & ~fwd_q: rcnt+1.
  - fwd_q & rev_q: neither counter increments; the overlap latch is set.
  - Neither pin high: no change.
- Edge detect compares fwd_q/rev_q against their previous values; any change sets the activity latch.
- Window end, computed with the end-cycle sample included:
  - diff = fcnt - rcnt, evaluated at DUTY_W+1 bits.
  - diff is clamped to [-(2^PERIOD_W-1), +(2^PERIOD_W-1)], so -1024 is never produced at defaults.
  - duty is loaded with the clamped diff on the next clock edge, with duty_vld=1 for that cycle.
  - overlap_err and active are loaded from their latches on the same edge.
  - fcnt, rcnt and both latches clear for the new window.
- State machine:
  - WARMUP: entered on rst. The first window after reset counts normally, but its result is discarded: no duty_vld, and outputs are left at their reset values. Moves to RUN at the end of the first window.
  - RUN: publishes every window.
- Phase independence: for a steady duty D with period 2^PERIOD_W, any window alignment counts exactly D high cycles. No edge alignment is required.
- Direction change mid-window: the result is the net fcnt - rcnt. For example, fwd 300 cycles then rev 100 cycles gives +200.
- Constant-high fwd for a full window gives fcnt = 1024, which clamps to +1023. Constant-high rev gives -1023.
- Both pins low for a whole window: duty = 0, active = 0.
- Reset values: duty = 0, duty_vld = 0, overlap_err = 0, active = 0, all counters 0, state WARMUP.
- Reset mid-window: all partial counts are discarded, win_cnt restarts at 0, and WARMUP repeats. No duty_vld is asserted in the cycle rst is high or the following window.
- Steady-state output latency: duty reflects the window ending 1 cycle earlier, plus 1 cycle of input registering.

Test Plan:
- Reset for 2 clocks, drive motor_cntrl with lft = 63 (fwd duty 63/1024) → no duty_vld in the first window; duty_vld every 1024 clocks after that, with duty = 63, overlap_err = 0, active = 1.
- rht = -127 (rev high 127 of 1024), with the decoder window phase offset by 500 clocks from the PWM period → duty = -127 on every update.
- Hold fwd = 1 and rev = 0 for 3 windows → duty = +1023, active = 0 from the second published window onward. Then hold both low for a full window → duty = 0.
- Force fwd = rev = 1 for 5 cycles inside a window, with fwd otherwise at 200/1024 → duty = 195 (overlap cycles not counted), overlap_err = 1 for that window only, and 0 the next.
- Switch command from +300 to -100 at a PWM boundary that falls mid-window → one transitional duty equal to the net count, then -100 steadily. No spurious duty_vld pulses.
- Assert rst for 1 cycle at win_cnt = 700 → outputs return to 0, the next duty_vld arrives exactly 2048 cycles after rst deasserts, and its value is correct.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers the signed drive command from a
// fwd/rev PWM pin pair by counting high time over fixed windows.
module pwm_duty_decoder #(
  parameter int PERIOD_W = 10,
  parameter int DUTY_W   = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fwd,
  input  logic                     rev,
  output logic signed [DUTY_W-1:0] duty,
  output logic                     duty_vld,
  output logic                     overlap_err,
  output logic                     active
);

  // Symmetric clamp limits; the most negative code is never produced.
  localparam logic signed [DUTY_W:0] DMAX =
    $signed({2'b00, {PERIOD_W{1'b1}}});
  localparam logic signed [DUTY_W:0] DMIN = -DMAX;

  typedef enum logic {
    WARMUP,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic fwd_q;
  logic rev_q;
  logic fwd_p;
  logic rev_p;

  logic [PERIOD_W-1:0] win_cnt;
  logic [PERIOD_W:0]   fcnt;
  logic [PERIOD_W:0]   rcnt;
  logic [PERIOD_W:0]   fcnt_nx;
  logic [PERIOD_W:0]   rcnt_nx;

  logic ovl_l;
  logic act_l;
  logic ovl_nx;
  logic act_nx;

  logic inc_f;
  logic inc_r;
  logic both;
  logic edge_seen;
  logic win_end;
  logic publish;

  logic signed [DUTY_W:0]   diff;
  logic signed [DUTY_W-1:0] clamp;

  // Register the pins once and keep the previous sample for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q <= 1'b0;
      rev_q <= 1'b0;
      fwd_p <= 1'b0;
      rev_p <= 1'b0;
    end else begin
      fwd_q <= fwd;
      rev_q <= rev;
      fwd_p <= fwd_q;
      rev_p <= rev_q;
    end
  end

  // Per-cycle increments and end-of-window totals incl. this sample.
  always_comb begin
    inc_f     = fwd_q & ~rev_q;
    inc_r     = rev_q & ~fwd_q;
    both      = fwd_q & rev_q;
    edge_seen = (fwd_q ^ fwd_p) | (rev_q ^ rev_p);
    win_end   = &win_cnt;
    fcnt_nx   = fcnt + {{PERIOD_W{1'b0}}, inc_f};
    rcnt_nx   = rcnt + {{PERIOD_W{1'b0}}, inc_r};
    ovl_nx    = ovl_l | both;
    act_nx    = act_l | edge_seen;
  end

  // Net count, widened one bit so the subtraction cannot wrap.
  always_comb begin
    diff = $signed({1'b0, fcnt_nx}) - $signed({1'b0, rcnt_nx});
    if (diff > DMAX) begin
      clamp = DMAX[DUTY_W-1:0];
    end else if (diff < DMIN) begin
      clamp = DMIN[DUTY_W-1:0];
    end else begin
      clamp = diff[DUTY_W-1:0];
    end
  end

  // Window counter, high-time counters and window latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      fcnt    <= '0;
      rcnt    <= '0;
      ovl_l   <= 1'b0;
      act_l   <= 1'b0;
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (win_end) begin
        fcnt  <= '0;
        rcnt  <= '0;
        ovl_l <= 1'b0;
        act_l <= 1'b0;
      end else begin
        fcnt  <= fcnt_nx;
        rcnt  <= rcnt_nx;
        ovl_l <= ovl_nx;
        act_l <= act_nx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WARMUP;
    end else begin
      state <= state_nx;
    end
  end

  // First window after reset is discarded; afterwards publish each.
  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    unique case (state)
      WARMUP: begin
        if (win_end) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        publish = win_end;
      end
    endcase
  end

  // Output registers, loaded only when a window is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty        <= '0;
      duty_vld    <= 1'b0;
      overlap_err <= 1'b0;
      active      <= 1'b0;
    end else begin
      duty_vld <= publish;
      if (publish) begin
        duty        <= clamp;
        overlap_err <= ovl_nx;
        active      <= act_nx;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed bench with a PWM source model
// and hand-driven pin patterns aligned to decoder windows.
module tb_pwm_duty_decoder;

  logic              clk;
  logic              rst;
  logic              fwd;
  logic              rev;
  logic signed [10:0] duty;
  logic              duty_vld;
  logic              overlap_err;
  logic              active;

  logic gen_on;
  logic gfwd;
  logic grev;
  logic mfwd;
  logic mrev;
  int   cmd;
  int   pwm_cnt;
  int   tests;
  int   fails;
  int   n;

  assign fwd = gen_on ? gfwd : mfwd;
  assign rev = gen_on ? grev : mrev;

  pwm_duty_decoder #(
    .PERIOD_W(10),
    .DUTY_W  (11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fwd        (fwd),
    .rev        (rev),
    .duty       (duty),
    .duty_vld   (duty_vld),
    .overlap_err(overlap_err),
    .active     (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running PWM source, period 1024, high at start of period.
  initial begin
    pwm_cnt = 0;
    gfwd    = 1'b0;
    grev    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gfwd    = (cmd > 0) && (pwm_cnt < cmd);
      grev    = (cmd < 0) && (pwm_cnt < -cmd);
      pwm_cnt = (pwm_cnt + 1) % 1024;
    end
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!duty_vld && cnt < lim);
  endtask

  function automatic logic [1:0] pat(input int mode, input int k);
    int   p;
    logic f;
    logic r;
    f = 1'b0;
    r = 1'b0;
    p = (k + 124) % 1024;
    case (mode)
      1: f = 1'b1;
      2: begin
        f = ((k % 1024) < 200);
        r = (k >= 50) && (k < 55);
      end
      3: begin
        if (k < 900) f = (p < 300);
        else         r = (p < 100);
      end
      default: ;
    endcase
    return {f, r};
  endfunction

  // Starts on a duty_vld negedge; ends on the next one.
  task automatic drive_window(input int mode, input int k0);
    int         spur;
    logic [1:0] v;
    spur = 0;
    v    = pat(mode, k0);
    mfwd = v[1];
    mrev = v[0];
    for (int j = 1; j <= 1023; j++) begin
      @(negedge clk);
      if (duty_vld) spur++;
      v    = pat(mode, k0 + j);
      mfwd = v[1];
      mrev = v[0];
    end
    @(negedge clk);
    chk("spurious_vld", spur, 0);
    chk("vld_at_end", duty_vld, 1);
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    gen_on = 1'b1;
    mfwd   = 1'b0;
    mrev   = 1'b0;
    cmd    = 63;

    repeat (2) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_vld", duty_vld, 0);
    chk("rst_ovl", overlap_err, 0);
    chk("rst_act", active, 0);

    rst = 1'b0;
    wait_vld(3000, n);
    chk("fwd63_first_vld", n, 2048);
    chk("fwd63_duty", duty, 63);
    chk("fwd63_ovl", overlap_err, 0);
    chk("fwd63_act", active, 1);
    @(negedge clk);
    chk("vld_pulse_len", duty_vld, 0);
    wait_vld(1100, n);
    chk("fwd63_period", n, 1023);
    chk("fwd63_duty2", duty, 63);

    cmd = -127;
    n   = 0;
    while (pwm_cnt != 500 && n < 2048) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_vld(3000, n);
    chk("rev127_first_vld", n, 2048);
    chk("rev127_duty", duty, -127);
    wait_vld(1100, n);
    chk("rev127_period", n, 1024);
    chk("rev127_duty2", duty, -127);
    chk("rev127_act", active, 1);
    chk("rev127_ovl", overlap_err, 0);

    gen_on = 1'b0;
    drive_window(1, 0);
    drive_window(1, 1024);
    chk("fwd_hi_duty", duty, 1023);
    chk("fwd_hi_act", active, 0);
    chk("fwd_hi_ovl", overlap_err, 0);
    drive_window(1, 2048);
    chk("fwd_hi_duty2", duty, 1023);
    chk("fwd_hi_act2", active, 0);

    drive_window(0, 0);
    chk("fall_duty", duty, 1);
    chk("fall_act", active, 1);
    drive_window(0, 1024);
    chk("idle_duty", duty, 0);
    chk("idle_act", active, 0);

    drive_window(2, 0);
    chk("ovl_duty", duty, 195);
    chk("ovl_flag", overlap_err, 1);
    chk("ovl_act", active, 1);
    drive_window(2, 1024);
    chk("ovl_next_duty", duty, 200);
    chk("ovl_next_flag", overlap_err, 0);

    drive_window(3, 0);
    chk("switch_net", duty, 76);
    drive_window(3, 1024);
    chk("switch_rev", duty, -100);
    drive_window(3, 2048);
    chk("switch_rev2", duty, -100);
    chk("switch_act", active, 1);

    cmd    = -100;
    gen_on = 1'b1;
    repeat (700) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_duty", duty, 0);
    chk("mid_rst_vld", duty_vld, 0);
    chk("mid_rst_act", active, 0);
    chk("mid_rst_ovl", overlap_err, 0);
    wait_vld(2100, n);
    chk("mid_rst_vld_delay", n, 2048);
    chk("mid_rst_duty_after", duty, -100);
    chk("mid_rst_act_after", active, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
